// File: rtl/lvl_delay_pipe.sv
// Per-channel programmable delay line, 0..MAX_DEPTH stages per channel.
// Depth changes wait for the channel to drain before they are applied.
module lvl_delay_pipe #(
  parameter int N_CH          = 16,
  parameter int DATA_W        = 32,
  parameter int MAX_DEPTH     = 4,
  parameter int TAP_W         = $clog2(MAX_DEPTH + 1),
  parameter int DEFAULT_DEPTH = 2,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_en,
  input  logic                     flush,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_vld,
  output logic [N_CH-1:0]          in_rdy,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [TAP_W-1:0]         cfg_depth,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          out_vld
);

  localparam logic [TAP_W-1:0] MAX_D = TAP_W'(MAX_DEPTH);
  localparam logic [TAP_W-1:0] DEF_D = TAP_W'(DEFAULT_DEPTH);

  logic            cfg_ok;
  logic            cfg_bad;
  logic [N_CH-1:0] pend;
  logic            err_q;

  assign cfg_ok   = cfg_we & (cfg_depth <= MAX_D);
  assign cfg_bad  = cfg_we & (cfg_depth > MAX_D);
  assign cfg_busy = |pend;
  assign cfg_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= cfg_bad;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [MAX_DEPTH-1:0]             sv;
    logic [MAX_DEPTH-1:0][DATA_W-1:0] sd;
    logic [TAP_W-1:0]                 dq;
    logic [TAP_W-1:0]                 pd;
    logic                             pq;
    logic                             acc;
    logic                             hit;
    logic                             empty;
    logic                             apply;
    logic                             adv;
    logic [MAX_DEPTH-1:0]             live;
    logic [DATA_W-1:0]                din;
    logic [DATA_W-1:0]                od;
    logic                             ov;

    assign din   = in_data[g*DATA_W +: DATA_W];
    assign acc   = in_vld[g] & ~pq;
    assign hit   = cfg_ok & (cfg_ch == CH_W'(g));
    assign apply = pq & empty;
    assign adv   = pipe_en & ~flush & ~apply;

    assign in_rdy[g] = ~pq;
    assign pend[g]   = pq;
    assign out_vld[g] = ov;
    assign out_data[g*DATA_W +: DATA_W] = od;

    // Only stages in front of the current tap count as in flight.
    always_comb begin
      live = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        live[i] = sv[i] & (TAP_W'(i) < dq);
      end
      empty = ~|live;
    end

    always_comb begin
      od = din;
      ov = acc;
      for (int t = 1; t <= MAX_DEPTH; t++) begin
        if (dq == TAP_W'(t)) begin
          od = sd[t-1];
          ov = sv[t-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sv <= '0;
      end else if (apply | flush) begin
        sv <= '0;
      end else if (pipe_en) begin
        sv[0] <= acc;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          sv[i] <= sv[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sd <= '0;
      end else if (adv) begin
        if (acc) sd[0] <= din;
        for (int i = 1; i < MAX_DEPTH; i++) begin
          if (sv[i-1]) sd[i] <= sd[i-1];
        end
      end
    end

    // A write landing with an apply re-arms pend with the newer depth.
    always_ff @(posedge clk) begin
      if (rst) begin
        dq <= DEF_D;
        pq <= 1'b0;
        pd <= '0;
      end else begin
        if (apply) dq <= pd;
        if (hit) begin
          pq <= 1'b1;
          pd <= cfg_depth;
        end else if (apply) begin
          pq <= 1'b0;
        end
      end
    end
  end

endmodule
